// File: rtl/mem_arb_rr_if.sv
// Bus bundles for the N-client burst memory arbiter.
//
// mem_arb_rr_client_if : the client-side bus, all clients packed side by side
//   (client i occupies slice i of every vector).
//   master = the clients (drive requests, address, data, burst length)
//   slave  = the arbiter (returns read data, per-client stall and read valid)
//
// mem_arb_rr_mm_if : the single Avalon-MM style memory-master port.
//   master = the arbiter (drives address, burst length, write data, rd/wr)
//   slave  = the memory controller (returns read data, stall, read valid)

interface mem_arb_rr_client_if #(
  parameter int NUM_CLIENTS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 3
);
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]     c_addr;
  logic [NUM_CLIENTS*BURSTLEN_WIDTH-1:0] c_burst_len;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     c_data_in;
  logic [NUM_CLIENTS-1:0]                c_wr;
  logic [NUM_CLIENTS-1:0]                c_rd;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     c_data_out;
  logic [NUM_CLIENTS-1:0]                c_waitrequest;
  logic [NUM_CLIENTS-1:0]                c_rd_valid;

  modport master (
    output c_addr, c_burst_len, c_data_in, c_wr, c_rd,
    input  c_data_out, c_waitrequest, c_rd_valid
  );

  modport slave (
    input  c_addr, c_burst_len, c_data_in, c_wr, c_rd,
    output c_data_out, c_waitrequest, c_rd_valid
  );
endinterface

interface mem_arb_rr_mm_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]     mm_addr;
  logic [BURSTLEN_WIDTH-1:0] mm_burst_len;
  logic [DATA_WIDTH-1:0]     mm_data_out;
  logic                      mm_wr;
  logic                      mm_rd;
  logic [DATA_WIDTH-1:0]     mm_data_in;
  logic                      mm_waitrequest;
  logic                      mm_rd_valid;

  modport master (
    output mm_addr, mm_burst_len, mm_data_out, mm_wr, mm_rd,
    input  mm_data_in, mm_waitrequest, mm_rd_valid
  );

  modport slave (
    input  mm_addr, mm_burst_len, mm_data_out, mm_wr, mm_rd,
    output mm_data_in, mm_waitrequest, mm_rd_valid
  );
endinterface

// File: rtl/mem_arb_rr.sv
// N-client arbiter sharing one burst-capable memory-master port.
//
// A winner is chosen in IDLE (round-robin from rr_ptr, or fixed priority with
// client 0 highest) and registered into grant; the grant is then held until the
// whole transaction (command + all read data beats, or all write beats) is done.
// Every return to IDLE costs one cycle before the next grant.
//
// Ports
//   clock    in  clock
//   reset_n  in  asynchronous, active-low reset
//   clients  client-side bus (slave modport): per-client rd/wr/addr/data/len in,
//            per-client waitrequest / rd_valid and broadcast read data out
//   mem      memory-side bus (master modport): one Avalon-MM style port

module mem_arb_rr #(
  parameter int NUM_CLIENTS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 3,
  parameter int PRIO_MODE      = 0   // 0 = round-robin, 1 = fixed priority
) (
  input  logic               clock,
  input  logic               reset_n,
  mem_arb_rr_client_if.slave clients,
  mem_arb_rr_mm_if.master    mem
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  typedef logic [IDX_W-1:0]          idx_t;
  typedef logic [BURSTLEN_WIDTH-1:0] len_t;
  typedef enum logic [1:0] {IDLE, CMD, WR_BURST, RD_DATA} state_t;

  state_t state, state_nxt;
  idx_t   grant, grant_nxt;
  idx_t   rr_ptr, rr_ptr_nxt;
  len_t   count, count_nxt;

  logic [NUM_CLIENTS-1:0] req;
  idx_t                   winner;

  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  len_t                  g_len;
  logic                  g_rd;
  logic                  g_wr;

  logic                   mm_rd_int;
  logic                   mm_wr_int;
  logic [NUM_CLIENTS-1:0] c_wait_int;
  logic [NUM_CLIENTS-1:0] c_rv_int;

  assign req = clients.c_rd | clients.c_wr;

  // Granted client's slice of every client vector.
  assign g_addr = clients.c_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_data = clients.c_data_in[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign g_len  = clients.c_burst_len[int'(grant)*BURSTLEN_WIDTH +: BURSTLEN_WIDTH];
  assign g_rd   = clients.c_rd[grant];
  assign g_wr   = clients.c_wr[grant];

  // Winner selection. The loop runs from the lowest-priority candidate up, so the
  // last hit (highest priority) is the one left in winner.
  always_comb begin : p_winner
    int cand;
    winner = '0;
    cand   = 0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (PRIO_MODE != 0) begin
        cand = k;
      end else begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      end
      if (req[cand]) winner = idx_t'(cand);
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a hold/default value first so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    count_nxt  = count;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = winner;
          state_nxt = CMD;
          if (PRIO_MODE == 0) begin
            rr_ptr_nxt = (int'(winner) == NUM_CLIENTS - 1) ? '0 : idx_t'(winner + 1'b1);
          end
        end
      end
      CMD: begin
        if (mm_rd_int && !mem.mm_waitrequest) begin
          count_nxt = g_len;
          state_nxt = RD_DATA;
        end else if (mm_wr_int && !mem.mm_waitrequest) begin
          if (g_len == '0) begin
            state_nxt = IDLE;
          end else begin
            count_nxt = len_t'(g_len - 1'b1);
            state_nxt = WR_BURST;
          end
        end else if (!req[grant]) begin
          // Granted client withdrew before being accepted: release the port
          // rather than waiting forever.
          state_nxt = IDLE;
        end
      end
      WR_BURST: begin
        if (mm_wr_int && !mem.mm_waitrequest) begin
          if (count == '0) state_nxt = IDLE;
          else             count_nxt = len_t'(count - 1'b1);
        end
      end
      RD_DATA: begin
        if (mem.mm_rd_valid) begin
          if (count == '0) state_nxt = IDLE;
          else             count_nxt = len_t'(count - 1'b1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    mm_rd_int  = 1'b0;
    mm_wr_int  = 1'b0;
    c_wait_int = '1;
    c_rv_int   = '0;
    case (state)
      CMD: begin
        // Read wins when a client raises both; the write is held off.
        mm_rd_int         = g_rd;
        mm_wr_int         = g_wr & ~g_rd;
        c_wait_int[grant] = mem.mm_waitrequest;
      end
      WR_BURST: begin
        // Only write beats belong to an open write burst; a read here would
        // never be tracked, so it is not forwarded.
        mm_wr_int         = g_wr;
        c_wait_int[grant] = mem.mm_waitrequest;
      end
      RD_DATA: begin
        c_rv_int[grant] = mem.mm_rd_valid;
      end
      default: ;
    endcase
  end

  assign mem.mm_addr      = g_addr;
  assign mem.mm_burst_len = g_len;
  assign mem.mm_data_out  = g_data;
  assign mem.mm_rd        = mm_rd_int;
  assign mem.mm_wr        = mm_wr_int;

  assign clients.c_data_out    = {NUM_CLIENTS{mem.mm_data_in}};
  assign clients.c_waitrequest = c_wait_int;
  assign clients.c_rd_valid    = c_rv_int;

endmodule

// File: tb/tb_mem_arb_rr.sv
// Self-checking bench for mem_arb_rr: a round-robin instance driven directly,
// plus a fixed-priority instance that shares the client stimulus during the
// fairness sequence. Write beats and read-valid pulses are checked against
// scoreboard queues filled when the stimulus is driven.

module tb_mem_arb_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_arb_rr_client_if #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) cif ();
  mem_arb_rr_mm_if     #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW))                   mif ();
  mem_arb_rr_client_if #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) fcif ();
  mem_arb_rr_mm_if     #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW))                   fmif ();

  logic fp_en;
  logic fp_valid;

  assign fcif.c_addr       = cif.c_addr;
  assign fcif.c_burst_len  = cif.c_burst_len;
  assign fcif.c_data_in    = cif.c_data_in;
  assign fcif.c_rd         = cif.c_rd & {N{fp_en}};
  assign fcif.c_wr         = cif.c_wr & {N{fp_en}};
  assign fmif.mm_data_in    = '0;
  assign fmif.mm_waitrequest = 1'b0;
  assign fmif.mm_rd_valid   = fp_valid;

  mem_arb_rr #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW), .PRIO_MODE(0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clients (cif),
    .mem     (mif)
  );

  mem_arb_rr #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW), .PRIO_MODE(1)) dut_fp (
    .clock   (clock),
    .reset_n (reset_n),
    .clients (fcif),
    .mem     (fmif)
  );

  int n_checks = 0;
  int n_errors = 0;

  int unsigned   rdv_q[$];
  logic [DW-1:0] wr_q[$];

  typedef struct {
    logic [N-1:0] rd;
    logic [N-1:0] wr;
    int unsigned  client;
    bit           is_rd;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_client(input int i, input logic [AW-1:0] a, input logic [BW-1:0] l,
                            input logic [DW-1:0] d);
    cif.c_addr[i*AW +: AW]      = a;
    cif.c_burst_len[i*BW +: BW] = l;
    cif.c_data_in[i*DW +: DW]   = d;
  endtask

  // Scoreboard monitor: inputs change on the falling edge, so +3 is stable.
  always @(negedge clock) begin : mon
    int unsigned  e;
    logic [N-1:0] oh;
    #3;
    if (reset_n) begin
      if (mif.mm_wr && !mif.mm_waitrequest) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected write beat: data 0x%0h", mif.mm_data_out);
        end else begin
          check("wr_beat_data", mif.mm_data_out, wr_q.pop_front());
        end
      end
      if (cif.c_rd_valid != '0) begin
        if (rdv_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected rd_valid: got 0x%0h", cif.c_rd_valid);
        end else begin
          e = rdv_q.pop_front();
          oh = '0;
          oh[e] = 1'b1;
          check("rd_valid_onehot", cif.c_rd_valid, oh);
          check("rd_data_slice", cif.c_data_out[e*DW +: DW], mif.mm_data_in);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t          tbl[9];
    logic [N-1:0]  exp_w;
    logic [5:0]    vpat;
    int            beats;
    int            got;
    int            fgot;
    logic          pend;
    logic          fpend;
    int unsigned   e;
    int unsigned   rr_exp_q[$];

    tbl[0] = '{rd: 4'b1111, wr: 4'b0000, client: 1, is_rd: 1'b1};
    tbl[1] = '{rd: 4'b0000, wr: 4'b0011, client: 0, is_rd: 1'b0};
    tbl[2] = '{rd: 4'b0001, wr: 4'b0001, client: 0, is_rd: 1'b1};
    tbl[3] = '{rd: 4'b1000, wr: 4'b0100, client: 2, is_rd: 1'b0};
    tbl[4] = '{rd: 4'b0110, wr: 4'b1000, client: 3, is_rd: 1'b0};
    tbl[5] = '{rd: 4'b0110, wr: 4'b0000, client: 1, is_rd: 1'b1};
    tbl[6] = '{rd: 4'b0000, wr: 4'b0010, client: 1, is_rd: 1'b0};
    tbl[7] = '{rd: 4'b1101, wr: 4'b0000, client: 2, is_rd: 1'b1};
    tbl[8] = '{rd: 4'b0111, wr: 4'b0000, client: 0, is_rd: 1'b1};

    cif.c_rd = '0;
    cif.c_wr = '0;
    for (int i = 0; i < N; i++) set_client(i, AW'(32'h1000 + i*16), '0, DW'(32'h5000_0000 + i));
    mif.mm_data_in     = '0;
    mif.mm_waitrequest = 1'b0;
    mif.mm_rd_valid    = 1'b0;
    fp_en    = 1'b0;
    fp_valid = 1'b0;

    // Reset values
    repeat (2) @(negedge clock);
    #1;
    check("rst_mm_rd", mif.mm_rd, 0);
    check("rst_mm_wr", mif.mm_wr, 0);
    check("rst_waitreq", cif.c_waitrequest, 4'hF);
    check("rst_rd_valid", cif.c_rd_valid, 0);
    check("rst_fp_waitreq", fcif.c_waitrequest, 4'hF);
    @(negedge clock);
    reset_n = 1'b1;

    // Single read, client 2
    @(negedge clock);
    set_client(2, 32'h100, 0, 32'h0);
    cif.c_rd[2] = 1'b1;
    #1;
    check("t1_latency_mm_rd", mif.mm_rd, 0);
    @(negedge clock);
    #1;
    check("t1_mm_rd", mif.mm_rd, 1);
    check("t1_mm_wr", mif.mm_wr, 0);
    check("t1_mm_addr", mif.mm_addr, 32'h100);
    check("t1_waitreq", cif.c_waitrequest, 4'b1011);
    @(negedge clock);
    cif.c_rd[2] = 1'b0;
    mif.mm_rd_valid = 1'b1;
    mif.mm_data_in  = 32'hCAFE_0002;
    rdv_q.push_back(2);
    #1;
    check("t1_rd_data_mm_rd", mif.mm_rd, 0);
    check("t1_rd_data_waitreq", cif.c_waitrequest, 4'hF);
    @(negedge clock);
    mif.mm_rd_valid = 1'b1;   // stray valid while idle
    mif.mm_data_in  = 32'h0000_0BAD;
    #1;
    check("t1_idle_valid_dropped", cif.c_rd_valid, 0);
    @(negedge clock);
    mif.mm_rd_valid = 1'b0;

    // Read burst client 1 (len 3) with stall, client 3 isolated meanwhile
    set_client(1, 32'h200, 3, 32'h0);
    cif.c_rd[1] = 1'b1;
    mif.mm_waitrequest = 1'b1;
    @(negedge clock);
    #1;
    check("t2_mm_rd", mif.mm_rd, 1);
    check("t2_mm_addr", mif.mm_addr, 32'h200);
    check("t2_mm_len", mif.mm_burst_len, 3);
    check("t2_stall_waitreq", cif.c_waitrequest, 4'hF);
    @(negedge clock);
    mif.mm_waitrequest = 1'b0;
    #1;
    check("t2_accept_waitreq", cif.c_waitrequest, 4'b1101);
    @(negedge clock);
    cif.c_rd[1] = 1'b0;
    set_client(3, 32'h300, 0, 32'h0);
    cif.c_rd[3] = 1'b1;
    vpat = 6'b110101;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      mif.mm_rd_valid = vpat[i];
      mif.mm_data_in  = DW'(32'hB000 + i);
      if (vpat[i]) rdv_q.push_back(1);
      #1;
      check("t2_rd_data_waitreq", cif.c_waitrequest, 4'hF);
      check("t2_isolate_rv3", cif.c_rd_valid[3], 0);
      check("t2_rd_data_mm_rd", mif.mm_rd, 0);
    end
    @(negedge clock);
    mif.mm_rd_valid = 1'b0;
    #1;
    check("t2_idle_mm_rd", mif.mm_rd, 0);
    check("t2_idle_wait3", cif.c_waitrequest[3], 1);
    @(negedge clock);
    #1;
    check("t2_c3_mm_rd", mif.mm_rd, 1);
    check("t2_c3_addr", mif.mm_addr, 32'h300);
    check("t2_c3_waitreq", cif.c_waitrequest, 4'b0111);
    @(negedge clock);
    cif.c_rd[3] = 1'b0;
    mif.mm_rd_valid = 1'b1;
    rdv_q.push_back(3);
    @(negedge clock);
    mif.mm_rd_valid = 1'b0;
    #1;
    check("t2_all_valids_seen", rdv_q.size(), 0);

    // Write burst client 0 (len 7) with toggling waitrequest
    set_client(0, 32'h400, 7, 32'hA000_0000);
    cif.c_wr[0] = 1'b1;
    for (int b = 0; b < 8; b++) wr_q.push_back(DW'(32'hA000_0000 + b));
    beats = 0;
    for (int i = 0; i < 60 && beats < 8; i++) begin
      @(negedge clock);
      cif.c_data_in[0 +: DW] = DW'(32'hA000_0000 + beats);
      mif.mm_waitrequest = ((i % 3) == 0);
      if (i == 4) cif.c_burst_len[0 +: BW] = '0;   // must be ignored mid-burst
      #1;
      if (mif.mm_wr && !mif.mm_waitrequest) beats++;
    end
    check("t3_beats", beats, 8);
    @(negedge clock);
    #1;
    check("t3_idle_mm_wr", mif.mm_wr, 0);
    check("t3_idle_waitreq", cif.c_waitrequest, 4'hF);
    check("t3_all_beats_seen", wr_q.size(), 0);
    cif.c_wr[0] = 1'b0;
    mif.mm_waitrequest = 1'b0;

    // Table of single-beat transactions: arbitration order and forwarding
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) set_client(i, AW'(32'h1000 + i*16), '0, DW'(32'h5000_0000 + i));
      cif.c_rd = tbl[k].rd;
      cif.c_wr = tbl[k].wr;
      #1;
      check("tbl_latency_rd", mif.mm_rd, 0);
      check("tbl_latency_wr", mif.mm_wr, 0);
      @(negedge clock);
      #1;
      exp_w = '1;
      exp_w[tbl[k].client] = 1'b0;
      check("tbl_mm_addr", mif.mm_addr, 32'h1000 + tbl[k].client*16);
      check("tbl_mm_rd", mif.mm_rd, tbl[k].is_rd);
      check("tbl_mm_wr", mif.mm_wr, !tbl[k].is_rd);
      check("tbl_mm_len", mif.mm_burst_len, 0);
      check("tbl_waitreq", cif.c_waitrequest, exp_w);
      if (!tbl[k].is_rd) wr_q.push_back(DW'(32'h5000_0000 + tbl[k].client));
      @(negedge clock);
      cif.c_rd = '0;
      cif.c_wr = '0;
      if (tbl[k].is_rd) begin
        mif.mm_rd_valid = 1'b1;
        mif.mm_data_in  = DW'(32'h7000 + k);
        rdv_q.push_back(tbl[k].client);
      end
      @(negedge clock);
      mif.mm_rd_valid = 1'b0;
    end

    // Reset in the middle of a 4-beat write burst (after beat 2)
    @(negedge clock);
    set_client(2, 32'h500, 3, 32'hC000_0000);
    cif.c_wr[2] = 1'b1;
    wr_q.push_back(32'hC000_0000);
    wr_q.push_back(32'hC000_0001);
    @(negedge clock);
    #1;
    check("t5_cmd_mm_wr", mif.mm_wr, 1);
    @(negedge clock);
    cif.c_data_in[2*DW +: DW] = 32'hC000_0001;
    #1;
    check("t5_burst_mm_wr", mif.mm_wr, 1);
    @(negedge clock);
    cif.c_data_in[2*DW +: DW] = 32'hC000_0002;
    reset_n = 1'b0;
    #1;
    check("t5_rst_mm_wr", mif.mm_wr, 0);
    check("t5_rst_mm_rd", mif.mm_rd, 0);
    check("t5_rst_waitreq", cif.c_waitrequest, 4'hF);
    check("t5_rst_rd_valid", cif.c_rd_valid, 0);
    check("t5_beats_before_rst", wr_q.size(), 0);
    cif.c_wr = '0;
    set_client(1, 32'h610, 0, 32'h0);
    set_client(3, 32'h630, 0, 32'h0);
    cif.c_rd = 4'b1010;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check("t5_post_rst_mm_rd", mif.mm_rd, 1);
    check("t5_post_rst_grant_addr", mif.mm_addr, 32'h610);
    @(negedge clock);
    cif.c_rd[1] = 1'b0;
    mif.mm_rd_valid = 1'b1;
    rdv_q.push_back(1);
    @(negedge clock);
    mif.mm_rd_valid = 1'b0;
    @(negedge clock);
    #1;
    check("t5_next_grant_addr", mif.mm_addr, 32'h630);
    check("t5_next_mm_rd", mif.mm_rd, 1);
    @(negedge clock);
    cif.c_rd[3] = 1'b0;
    mif.mm_rd_valid = 1'b1;
    rdv_q.push_back(3);
    @(negedge clock);
    mif.mm_rd_valid = 1'b0;

    // Fairness: all clients request single reads continuously
    for (int i = 0; i < N; i++) set_client(i, AW'(32'h1000 + i*16), '0, '0);
    rr_exp_q = '{0, 1, 2, 3, 0, 1};
    cif.c_rd = '1;
    fp_en    = 1'b1;
    pend  = 1'b0;
    fpend = 1'b0;
    got   = 0;
    fgot  = 0;
    for (int i = 0; i < 40 && got < 6; i++) begin
      @(negedge clock);
      mif.mm_rd_valid = pend;
      fp_valid        = fpend;
      pend  = 1'b0;
      fpend = 1'b0;
      #1;
      if (mif.mm_rd) begin
        e = rr_exp_q.pop_front();
        check("rr_grant_addr", mif.mm_addr, 32'h1000 + e*16);
        rdv_q.push_back(e);
        pend = 1'b1;
        got++;
      end
      if (fmif.mm_rd) begin
        check("fp_grant_addr", fmif.mm_addr, 32'h1000);
        fpend = 1'b1;
        fgot++;
      end
    end
    check("rr_grant_count", got, 6);
    check("fp_grant_count", fgot, 6);
    @(negedge clock);
    mif.mm_rd_valid = pend;
    fp_valid        = fpend;
    cif.c_rd = '0;
    fp_en    = 1'b0;
    @(negedge clock);
    mif.mm_rd_valid = 1'b0;
    fp_valid        = 1'b0;
    @(negedge clock);
    #1;
    check("end_rd_valid_queue", rdv_q.size(), 0);
    check("end_wr_beat_queue", wr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
